// File: rtl/mavg_sequencer.sv
// Sequences one filter run per divider tick: latch sample, pulse FILT_START, await FILT_VALID edge, publish result.
// Tick-to-DATA_VALID latency is START_LEN + filter cycles + 2; ticks arriving while busy are dropped and counted.
module mavg_sequencer #(
  parameter int BITSIZE   = 16,
  parameter int DIV_WIDTH = 16,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 63
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [DIV_WIDTH-1:0] DIVIDER,
  input  logic                 CLR_ERR,
  input  logic [BITSIZE-1:0]   ADC_DATA,
  output logic                 FILT_EN,
  output logic                 FILT_START,
  output logic [BITSIZE-1:0]   FILT_DIN,
  input  logic [BITSIZE-1:0]   FILT_DOUT,
  input  logic                 FILT_VALID,
  output logic [BITSIZE-1:0]   DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 BUSY,
  output logic                 ERR_TIMEOUT,
  output logic [7:0]           OVERRUN_CNT
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [SW-1:0]          start_cnt_q, start_cnt_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   en_q, en_d;
  logic                   fv_q, fv_d;
  logic [BITSIZE-1:0]     din_q, din_d;
  logic [BITSIZE-1:0]     dout_q, dout_d;
  logic                   err_q, err_d;
  logic [7:0]             ovr_q, ovr_d;
  logic                   tick;
  logic                   fv_edge;
  logic                   timeout;

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    start_cnt_d = start_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    din_d       = din_q;
    dout_d      = dout_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    en_d        = ENABLE;
    fv_d        = FILT_VALID;
    timeout     = 1'b0;

    tick    = ENABLE && (div_cnt_q == DIVIDER);
    fv_edge = FILT_VALID && !fv_q;

    if (!ENABLE || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          din_d       = ADC_DATA;
          start_cnt_d = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
        end else if (start_cnt_q == SW'(START_LEN - 1)) begin
          tmo_cnt_d = '0;
          state_d   = S_WAIT;
        end else begin
          start_cnt_d = start_cnt_q + SW'(1);
        end
      end
      S_WAIT: begin
        // Abort outranks a coincident result edge and the timeout.
        if (!ENABLE) begin
          state_d = S_IDLE;
        end else if (fv_edge) begin
          dout_d  = FILT_DOUT;
          state_d = S_DONE;
        end else if (tmo_cnt_q + TW'(1) == TW'(TIMEOUT)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      err_d = 1'b1;
    end else if (CLR_ERR) begin
      err_d = 1'b0;
    end

    if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      start_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      en_q        <= 1'b0;
      fv_q        <= 1'b0;
      din_q       <= '0;
      dout_q      <= '0;
      err_q       <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      start_cnt_q <= start_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      en_q        <= en_d;
      fv_q        <= fv_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign FILT_EN     = en_q;
  assign FILT_START  = (state_q == S_START);
  assign FILT_DIN    = din_q;
  assign DATA_OUT    = dout_q;
  assign DATA_VALID  = (state_q == S_DONE);
  assign BUSY        = (state_q != S_IDLE);
  assign ERR_TIMEOUT = err_q;
  assign OVERRUN_CNT = ovr_q;

endmodule

// File: tb/tb_mavg_sequencer.sv
// Directed bench for mavg_sequencer with a small behavioural filter model.
module tb_mavg_sequencer;
  localparam int BITSIZE   = 16;
  localparam int DIV_WIDTH = 16;
  localparam int START_LEN = 2;
  localparam int TIMEOUT   = 63;
  localparam logic [15:0] DOUT_XOR = 16'h0074;
  localparam int M_NORM = 0, M_LOW = 1, M_STUCK = 2;

  logic CLK, RST, ENABLE, CLR_ERR;
  logic [DIV_WIDTH-1:0] DIVIDER;
  logic [BITSIZE-1:0] ADC_DATA, FILT_DIN, FILT_DOUT, DATA_OUT;
  logic FILT_EN, FILT_START, FILT_VALID, DATA_VALID, BUSY, ERR_TIMEOUT;
  logic [7:0] OVERRUN_CNT;

  mavg_sequencer #(.BITSIZE(BITSIZE), .DIV_WIDTH(DIV_WIDTH), .START_LEN(START_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .DIVIDER(DIVIDER), .CLR_ERR(CLR_ERR),
    .ADC_DATA(ADC_DATA), .FILT_EN(FILT_EN), .FILT_START(FILT_START), .FILT_DIN(FILT_DIN),
    .FILT_DOUT(FILT_DOUT), .FILT_VALID(FILT_VALID), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
    .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT), .OVERRUN_CNT(OVERRUN_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Filter model: raises FILT_VALID flt_lat cycles after the FILT_START fall, for 2 cycles.
  int flt_mode = M_LOW;
  int flt_lat  = 10;
  int cd, hold;
  logic m_fs_prev;
  initial begin
    FILT_VALID = 1'b0; FILT_DOUT = '0; cd = 0; hold = 0; m_fs_prev = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (flt_mode == M_STUCK) begin
        FILT_VALID = 1'b1; FILT_DOUT = 16'hDEAD; cd = 0; hold = 0;
      end else if (flt_mode == M_LOW) begin
        FILT_VALID = 1'b0; cd = 0; hold = 0;
      end else begin
        if (hold > 0) hold--;
        if (hold == 0) FILT_VALID = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            FILT_VALID = 1'b1; FILT_DOUT = FILT_DIN ^ DOUT_XOR; hold = 2;
          end
        end
        if (m_fs_prev && !FILT_START) cd = flt_lat;
      end
      m_fs_prev = FILT_START;
    end
  end

  task automatic go_idle(input int n);
    @(posedge CLK); #1;
    ENABLE = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic run_timeout(input int mode, input string tag);
    int fall_i, err_i, dv_n;
    logic fs_p, busy_p;
    flt_mode = mode;
    go_idle(4);
    DIVIDER = 16'd99; ENABLE = 1'b1;
    fall_i = -1; err_i = -1; dv_n = 0; fs_p = 1'b0; busy_p = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (fs_p && !FILT_START && fall_i < 0) fall_i = i;
      if (DATA_VALID) dv_n++;
      if (ERR_TIMEOUT) begin
        err_i = i;
        check({tag, "_busy_at_err"}, BUSY, 0);
        check({tag, "_busy_before_err"}, busy_p, 1);
        break;
      end
      busy_p = BUSY;
      fs_p = FILT_START;
    end
    check({tag, "_wait_cycles"}, err_i - fall_i, TIMEOUT);
    check({tag, "_no_dv"}, dv_n, 0);
    check({tag, "_dout_kept"}, DATA_OUT, 16'h8010);
    @(posedge CLK); #1; ENABLE = 1'b0;
    @(negedge CLK);
    check({tag, "_err_sticky"}, ERR_TIMEOUT, 1);
    @(posedge CLK); #1; CLR_ERR = 1'b1;
    @(posedge CLK); #1; CLR_ERR = 1'b0;
    @(negedge CLK);
    check({tag, "_err_cleared"}, ERR_TIMEOUT, 0);
  endtask

  logic fs_prev, found;
  int rise_n, fs_hi, dv_n, first_rise, dv_first, dv_last, k;
  logic [15:0] adc_cur, adc_prev, exp_pend;

  initial begin
    RST = 1'b1; ENABLE = 1'b0; DIVIDER = '0; CLR_ERR = 1'b0; ADC_DATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_filt_start", FILT_START, 0);
    check("rst_data_valid", DATA_VALID, 0);
    check("rst_err", ERR_TIMEOUT, 0);
    check("rst_ovr", OVERRUN_CNT, 0);
    check("rst_dout", DATA_OUT, 0);
    @(posedge CLK); #1; RST = 1'b0;

    // Nominal: DIVIDER=19, filter answers 10 cycles after FILT_START falls.
    flt_mode = M_NORM; flt_lat = 10; DIVIDER = 16'd19; ADC_DATA = 16'h8064;
    @(posedge CLK); #1; ENABLE = 1'b1;
    fs_prev = 1'b0; rise_n = 0; fs_hi = 0; dv_n = 0; first_rise = -1; dv_first = -1; dv_last = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (i == 0) check("nom_filt_en_lag0", FILT_EN, 0);
      if (i == 1) check("nom_filt_en_lag1", FILT_EN, 1);
      if (i == 19) check("nom_busy_at_tick", BUSY, 0);
      if (i == 20) check("nom_busy_after_tick", BUSY, 1);
      if (FILT_START) fs_hi++;
      if (FILT_START && !fs_prev) begin
        rise_n++;
        if (first_rise < 0) first_rise = i;
        check("nom_filt_din", FILT_DIN, 16'h8064);
      end
      if (DATA_VALID) begin
        check("nom_data_out", DATA_OUT, 16'h8010);
        if (dv_first < 0) dv_first = i;
        else check("nom_period", i - dv_last, 20);
        dv_last = i;
        dv_n++;
      end
      fs_prev = FILT_START;
    end
    check("nom_first_rise", first_rise, 20);
    check("nom_start_pulses", rise_n, 3);
    check("nom_start_cycles", fs_hi, 3 * START_LEN);
    check("nom_dv_count", dv_n, 3);
    check("nom_latency", dv_first - (first_rise - 1), START_LEN + 10 + 2);

    run_timeout(M_LOW, "tmo");
    run_timeout(M_STUCK, "stale");

    // Abort: ENABLE drops in the same cycle as the FILT_VALID rising edge.
    flt_mode = M_NORM; flt_lat = 10; ADC_DATA = 16'h1234;
    go_idle(3);
    DIVIDER = 16'd19; ENABLE = 1'b1;
    fs_prev = 1'b0; found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (fs_prev && !FILT_START) begin found = 1'b1; break; end
      fs_prev = FILT_START;
    end
    check("abort_reached_wait", found, 1);
    repeat (10) @(posedge CLK);
    #1; ENABLE = 1'b0;
    @(negedge CLK);
    check("abort_busy_in_wait", BUSY, 1);
    check("abort_filt_en_hi", FILT_EN, 1);
    @(negedge CLK);
    check("abort_idle", BUSY, 0);
    check("abort_no_dv", DATA_VALID, 0);
    check("abort_dout_kept", DATA_OUT, 16'h8010);
    check("abort_filt_en_lo", FILT_EN, 0);
    dv_n = 0;
    repeat (5) begin @(negedge CLK); if (DATA_VALID) dv_n++; end
    check("abort_no_late_dv", dv_n, 0);
    check("pre_ovr_zero", OVERRUN_CNT, 0);

    // Overrun: DIVIDER=3 with a 20-cycle filter drops 6 ticks per 28-cycle run.
    flt_lat = 20;
    go_idle(3);
    DIVIDER = 16'd3; ENABLE = 1'b1; adc_cur = 16'hA000; ADC_DATA = adc_cur;
    adc_prev = '0; exp_pend = '0; fs_prev = 1'b0; dv_n = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if (i == 8) check("ovr_first", OVERRUN_CNT, 1);
      if (i == 30) check("ovr_one_run", OVERRUN_CNT, 6);
      if (FILT_START && !fs_prev) begin
        if (FILT_DIN !== adc_prev) check("ovr_filt_din", FILT_DIN, adc_prev);
        exp_pend = adc_prev ^ DOUT_XOR;
      end
      if (DATA_VALID) begin
        dv_n++;
        if (DATA_OUT !== exp_pend) check("ovr_data_out", DATA_OUT, exp_pend);
      end
      fs_prev = FILT_START;
      adc_prev = adc_cur;
      @(posedge CLK); #1;
      adc_cur = 16'hA000 + 16'(i + 1);
      ADC_DATA = adc_cur;
    end
    check("ovr_saturated", OVERRUN_CNT, 255);
    check("ovr_dv_count", dv_n, 53);

    // Reset pulse while FILT_START is high, then resume.
    flt_lat = 10; ADC_DATA = 16'h5A5A;
    go_idle(3);
    DIVIDER = 16'd19; ENABLE = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (FILT_START) begin found = 1'b1; break; end
    end
    check("rstmid_start_seen", found, 1);
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    check("rstmid_filt_start", FILT_START, 0);
    check("rstmid_dv", DATA_VALID, 0);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_filt_en", FILT_EN, 0);
    check("rstmid_filt_din", FILT_DIN, 0);
    check("rstmid_dout", DATA_OUT, 0);
    check("rstmid_ovr", OVERRUN_CNT, 0);
    k = 0; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      k++;
      if (FILT_START) begin found = 1'b1; break; end
    end
    check("resume_start_delay", found ? k : -1, 20);
    check("resume_filt_din", FILT_DIN, 16'h5A5A);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DATA_VALID) begin found = 1'b1; break; end
    end
    check("resume_dv_seen", found, 1);
    check("resume_data_out", DATA_OUT, 16'h5A5A ^ DOUT_XOR);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
